// File: rtl/gf2m_digit_serial_mul.sv
// rtl/gf2m_digit_serial_mul.sv - digit-serial GF(2^M) polynomial-basis multiplier
//
// Computes P = A*B mod f(x), f(x) = x^M + G(x), M = W*N. Operands stream in
// as W-bit digits, most-significant digit first. The product streams out the
// same way.
//
// Ports:
//   clk     in   1  rising-edge clock
//   rst     in   1  synchronous active-high reset
//   ctr     in   1  load strobe: ai/gi digit valid this cycle
//   ai      in   W  A digit, ai[W] = MSB
//   gi      in   W  G digit (low M coefficients of f), gi[W] = MSB
//   bi      in   W  B digit, leads ai/gi by one cycle, bi[W] = MSB
//   po      out  W  P digit, po[1] = MSB
//   po_vld  out  1  high on the N output cycles (only with GF_MUL_VALID_EN)
//
// Optional feature macro: GF_MUL_VALID_EN adds the po_vld output.

module gf2m_digit_serial_mul #(
  parameter int W = 8,
  parameter int N = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctr,
  input  logic [W:1] ai,
  input  logic [W:1] gi,
  input  logic [W:1] bi,
  output logic [1:W] po
`ifdef GF_MUL_VALID_EN
  ,
  output logic       po_vld
`endif
);

  localparam int M     = W * N;
  localparam int CNT_W = ($clog2(N) > 0) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_OUTPUT  = 2'd2
  } state_t;

  state_t           state_q;
  logic [M-1:0]     a_q;
  logic [M-1:0]     b_q;
  logic [M-1:0]     g_q;
  logic [M-1:0]     p_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     bi_dly_q;
  logic [W-1:0]     po_q;
  logic             po_vld_q;

  logic [W-1:0]     ai_w;
  logic [W-1:0]     gi_w;
  logic [W-1:0]     bi_w;

  logic [M-1:0]     p_mul_d;
  logic [M-1:0]     a_mul_d;

  assign ai_w = ai;
  assign gi_w = gi;
  assign bi_w = bi;
  assign po   = po_q;

`ifdef GF_MUL_VALID_EN
  assign po_vld = po_vld_q;
`endif

  // W unrolled MSB-first shift-and-add steps with interleaved reduction:
  // multiply P by x, fold the overflowing x^M term back in as G, then add B
  // when the current A bit is set.
  always_comb begin
    p_mul_d = p_q;
    a_mul_d = a_q;
    for (int i = 0; i < W; i++) begin
      p_mul_d = {p_mul_d[M-2:0], 1'b0} ^ (p_mul_d[M-1] ? g_q : '0);
      if (a_mul_d[M-1]) begin
        p_mul_d = p_mul_d ^ b_q;
      end
      a_mul_d = {a_mul_d[M-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      g_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      bi_dly_q <= '0;
      po_q     <= '0;
      po_vld_q <= 1'b0;
    end else begin
      // The B delay register samples every cycle so that the B top digit
      // presented during the last output cycle is ready for a back-to-back
      // load; outside IDLE its value is never consumed otherwise.
      bi_dly_q <= bi_w;
      case (state_q)
        S_IDLE: begin
          po_q     <= '0;
          po_vld_q <= 1'b0;
          if (ctr) begin
            a_q <= {a_q[M-W-1:0], ai_w};
            g_q <= {g_q[M-W-1:0], gi_w};
            b_q <= {b_q[M-W-1:0], bi_dly_q};
            if (cnt_q == CNT_LAST) begin
              cnt_q   <= '0;
              p_q     <= '0;
              state_q <= S_COMPUTE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          po_q     <= '0;
          po_vld_q <= 1'b0;
          p_q      <= p_mul_d;
          a_q      <= a_mul_d;
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_OUTPUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_OUTPUT: begin
          po_q     <= p_q[M-1 -: W];
          po_vld_q <= 1'b1;
          p_q      <= {p_q[M-W-1:0], {W{1'b0}}};
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          cnt_q    <= '0;
          po_q     <= '0;
          po_vld_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_digit_serial_mul.sv
// tb/tb_gf2m_digit_serial_mul.sv - scoreboard bench for gf2m_digit_serial_mul

module tb_gf2m_digit_serial_mul;

  localparam int W = 8;
  localparam int N = 21;
  localparam int M = W * N;

  typedef struct {
    int           e;
    logic [W-1:0] v;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         ctr;
  logic [W-1:0] ai;
  logic [W-1:0] gi;
  logic [W-1:0] bi;
  logic [W-1:0] po;
`ifdef GF_MUL_VALID_EN
  logic         po_vld;
`endif

  int   ec;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  logic [M-1:0] g_std;
  logic [M-1:0] a_v;
  logic [M-1:0] b_v;
  logic [M-1:0] p_v;
  logic [191:0] rnd;

  gf2m_digit_serial_mul #(.W(W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .ctr (ctr),
    .ai  (ai),
    .gi  (gi),
    .bi  (bi),
    .po  (po)
`ifdef GF_MUL_VALID_EN
    ,
    .po_vld (po_vld)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) ec <= ec + 1;

  // Schoolbook carry-less product followed by top-down reduction.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                          input logic [M-1:0] b,
                                          input logic [M-1:0] g);
    logic [2*M-2:0] pr;
    logic [M:0]     f;
    pr = '0;
    f  = {1'b1, g};
    for (int i = 0; i < M; i++)
      if (b[i]) pr = pr ^ ({{(M-1){1'b0}}, a} << i);
    for (int d = 2*M-2; d >= M; d--)
      if (pr[d]) pr = pr ^ ({{(M-2){1'b0}}, f} << (d - M));
    return pr[M-1:0];
  endfunction

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (ec >= 1) begin
        checks++;
        if (sb_q.size() > 0 && sb_q[0].e == ec) begin
          if (po !== sb_q[0].v) begin
            errors++;
            $display("FAIL po_digit edge=%0d got=%02h exp=%02h", ec, po, sb_q[0].v);
          end
`ifdef GF_MUL_VALID_EN
          if (po_vld !== 1'b1) begin
            errors++;
            $display("FAIL po_vld_hi edge=%0d got=%0b exp=1", ec, po_vld);
          end
`endif
          void'(sb_q.pop_front());
        end else if (sb_q.size() > 0 && sb_q[0].e < ec) begin
          errors++;
          $display("FAIL po_missed edge=%0d got=none exp_edge=%0d", ec, sb_q[0].e);
          void'(sb_q.pop_front());
        end else if (po !== '0) begin
          errors++;
          $display("FAIL po_idle edge=%0d got=%02h exp=00", ec, po);
        end
      end
    end
  endtask

  // gap_at: digit index before whose capture 3 idle cycles are inserted (-1 = none).
  task automatic do_load(input logic [M-1:0] a, input logic [M-1:0] b,
                         input logic [M-1:0] g, input int gap_at,
                         input bit push, input logic [M-1:0] p_exp);
    int e_last;
    e_last = 0;
    @(negedge clk);
    ctr = 1'b0;
    ai  = '0;
    gi  = '0;
    bi  = b[M-1 -: W];
    for (int k = N-1; k >= 0; k--) begin
      if (k == gap_at) begin
        repeat (3) begin
          @(negedge clk);
          ctr = 1'b0;
        end
      end
      @(negedge clk);
      ctr = 1'b1;
      ai  = a[k*W +: W];
      gi  = g[k*W +: W];
      bi  = (k > 0) ? b[(k-1)*W +: W] : '0;
      if (k == 0) e_last = ec + 1;
    end
    @(negedge clk);
    ctr = 1'b0;
    ai  = '0;
    gi  = '0;
    bi  = '0;
    if (push) begin
      for (int d = N-1; d >= 0; d--)
        sb_q.push_back('{e_last + N + (N - d), p_exp[d*W +: W]});
    end
    repeat (2*N + 1) @(negedge clk);
  endtask

  initial begin
    ec     = 0;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    ctr    = 1'b0;
    ai     = '0;
    gi     = '0;
    bi     = '0;
    g_std  = '0;
    g_std[15:0] = 16'h1920;

    fork
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // T1 identity
    a_v = '0; a_v[0] = 1'b1;
    b_v = '0; b_v[7:0] = 8'h8D;
    p_v = '0; p_v[7:0] = 8'h8D;
    do_load(a_v, b_v, g_std, -1, 1'b1, p_v);

    // T2 reduction: x * x^167 = x^168 = G
    a_v = '0; a_v[1] = 1'b1;
    b_v = '0; b_v[M-1] = 1'b1;
    p_v = '0; p_v[15:0] = 16'h1920;
    do_load(a_v, b_v, g_std, -1, 1'b1, p_v);

    // T3 zero
    a_v = '0;
    b_v = '1;
    p_v = '0;
    do_load(a_v, b_v, g_std, -1, 1'b1, p_v);

    // T4 gapped T2
    a_v = '0; a_v[1] = 1'b1;
    b_v = '0; b_v[M-1] = 1'b1;
    p_v = '0; p_v[15:0] = 16'h1920;
    do_load(a_v, b_v, g_std, 10, 1'b1, p_v);

    // T5 reset mid-compute, then T1
    a_v = '0; a_v[0] = 1'b1;
    b_v = '0; b_v[7:0] = 8'h8D;
    fork
      do_load(a_v, b_v, g_std, -1, 1'b0, '0);
      begin
        repeat (N + 6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    join
    p_v = '0; p_v[7:0] = 8'h8D;
    do_load(a_v, b_v, g_std, -1, 1'b1, p_v);

    // T6 random against the software model
    for (int t = 0; t < 100; t++) begin
      for (int j = 0; j < 6; j++) rnd[j*32 +: 32] = $urandom;
      a_v = rnd[M-1:0];
      for (int j = 0; j < 6; j++) rnd[j*32 +: 32] = $urandom;
      b_v = rnd[M-1:0];
      p_v = gf_mul(a_v, b_v, g_std);
      do_load(a_v, b_v, g_std, -1, 1'b1, p_v);
    end

    for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout got=%0d pending exp=0", sb_q.size());
    end
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
